adc_capture: RTL and testbench
==============================

ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameter CLK_DIV, default 4, is the i_clk cycles per o_adclk period; legal values are even, 4..16.
REQ-002 Parameter FIFO_DEPTH, default 16, is the sample buffer depth; legal values are powers of 2, 4..64.
REQ-003 Parameter SIGNED_OUT, default 0: 1 = two's complement out (MSB inverted), 0 = offset binary passthrough.
REQ-004 i_clk  input  1  single clock (25 MHz board clock); all logic on rising edge.
REQ-005 i_reset  input  1  reset, asynchronous, active-high.
REQ-006 i_enable  input  1  level; 1 = run conversion clock and capture.
REQ-007 i_ad_data  input  8  ADC parallel data bus (ADDB7..ADDB0), from board pins.
REQ-008 o_adclk  output  1  conversion clock driven to ADC pin ADCLK.
REQ-009 o_data  output  8  sample at FIFO head.
REQ-010 o_valid  output  1  o_data holds an unread sample.
REQ-011 i_ready  input  1  downstream (DAC stage) accepts o_data this cycle.
REQ-012 o_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 o_overflow  output  1  sticky: a sample was dropped because the FIFO was full.
REQ-014 i_clr_overflow  input  1  one-cycle pulse clears o_overflow.

Function
REQ-015 States SHALL be IDLE and RUN; IDLE->RUN when i_enable=1 in IDLE; RUN->IDLE only when i_enable=0 and divider count = CLK_DIV-1.
REQ-016 Divider count SHALL run 0..CLK_DIV-1, wrap to 0, and hold 0 in IDLE.
REQ-017 o_adclk SHALL be registered, 1 while in RUN with count < CLK_DIV/2, else 0; o_adclk is 0 in IDLE (no runt pulses on enable/disable).
REQ-018 i_ad_data SHALL be registered every cycle into an input register (one-stage pipeline).
REQ-019 In RUN, when count = CLK_DIV-1, the input register value SHALL be pushed to the FIFO (one sample per o_adclk period).
REQ-020 With SIGNED_OUT=1, bit 7 SHALL be inverted before the push; bits 6:0 unchanged.
REQ-021 FIFO SHALL be first-word-fall-through: o_valid = (o_level != 0); o_data valid whenever o_valid=1.
REQ-022 Pop SHALL occur exactly on cycles with o_valid=1 and i_ready=1; o_data/o_valid stable while o_valid=1 and i_ready=0.
REQ-023 Push latency: a pushed sample SHALL appear on o_data (if FIFO was empty) on the next cycle.
REQ-024 Push when full and no pop same cycle: sample dropped, contents unchanged, o_overflow set next cycle.
REQ-025 Push and pop same cycle when full: both SHALL succeed, o_level unchanged, no overflow.
REQ-026 Push and pop same cycle when empty: impossible (o_valid=0); push only, o_level becomes 1.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; o_level SHALL never exceed FIFO_DEPTH.
REQ-028 i_clr_overflow and a new overflow in the same cycle: o_overflow SHALL be 1 (set wins).
REQ-029 Entering IDLE SHALL NOT flush the FIFO; buffered samples remain poppable.

Reset
REQ-030 On i_reset=1, immediately: state IDLE, count 0, o_adclk 0, FIFO pointers 0, o_level 0, o_valid 0, o_overflow 0, o_data 8'h00, input register 8'h00.
REQ-031 Reset asserted mid-RUN SHALL discard all buffered samples; first o_adclk high occurs no earlier than 2 cycles after reset release with i_enable=1.

Structure
REQ-032 Package adda_pkg SHALL hold SAMPLE_W=8 and typedef sample_t (logic [7:0]), shared with the DAC output stage.
REQ-033 FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty, level, wdata, rdata).

Verification
REQ-034 Reset, i_enable=1, CLK_DIV=4, i_ready=1 -> o_adclk 1100 repeating; ramp 0x00,0x01,.. on i_ad_data appears in order on o_data, one sample per 4 cycles.
REQ-035 SIGNED_OUT=1, i_ad_data=8'h80 constant -> o_data=8'h00; 8'hFF -> 8'h7F.
REQ-036 i_ready=0, FIFO_DEPTH=16, run 20 periods -> o_level=16, o_overflow=1, first 16 samples retained; i_clr_overflow pulse -> o_overflow=0.
REQ-037 FIFO full, i_ready=1 on exactly the push cycle -> o_level stays 16, o_overflow stays 0, no sample lost.
REQ-038 Drop i_enable at count=1 -> o_adclk completes current period, then 0; 4 buffered samples still drain with i_ready=1.
REQ-039 Assert i_reset mid-RUN with o_level=5 -> o_level=0, o_valid=0, o_adclk=0 in the same cycle (asynchronous).

Source files
------------

// File: rtl/adda_pkg.sv
// Shared ADC/DAC sample types and capture FSM encodings.
// Imported by the capture front end and the DAC output stage.
package adda_pkg;

  localparam int SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Offset binary to two's complement: flip the MSB only.
  function automatic sample_t to_signed(input sample_t s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// A push into a full FIFO only lands when a pop frees a slot that cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_wr, do_rd;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;
  assign rdata = empty ? '0 : mem_q[rptr_q];

  assign do_rd = pop && !empty;
  assign do_wr = push && (!full || do_rd);

  always_comb begin
    wptr_d  = wptr_q + AW'(do_wr);
    rptr_d  = rptr_q + AW'(do_rd);
    level_d = level_q + LW'(do_wr) - LW'(do_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/adc_capture.sv
// Parallel ADC front end: generates ADCLK, samples the bus once per
// conversion period and buffers samples for the DAC stage.
module adc_capture
  import adda_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int SIGNED_OUT = 0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  sample_t                       i_ad_data,
  output logic                          o_adclk,
  output sample_t                       o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow,
  input  logic                          i_clr_overflow
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          adclk_q, adclk_d;
  logic          ovf_q, ovf_d;
  sample_t       din_q;
  sample_t       wdata;
  logic          last, push, pop, drop;
  logic          full, empty;

  assign last = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
  assign push = last;
  assign pop  = o_valid && i_ready;
  assign drop = push && full && !pop;

  assign wdata = (SIGNED_OUT != 0) ? to_signed(din_q) : din_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last && !i_enable) state_d = ST_IDLE;
      end
    endcase
  end

  // Registered from the current count, so pulses are always full width.
  assign adclk_d = (state_q == ST_RUN) && (cnt_q < CNT_HALF);
  assign ovf_d   = drop ? 1'b1 : (i_clr_overflow ? 1'b0 : ovf_q);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adclk_q <= 1'b0;
      ovf_q   <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adclk_q <= adclk_d;
      ovf_q   <= ovf_d;
      din_q   <= i_ad_data;
    end
  end

  assign o_adclk    = adclk_q;
  assign o_overflow = ovf_q;
  assign o_valid    = !empty;

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (o_data),
    .full  (full),
    .empty (empty),
    .level (o_level)
  );

endmodule

// File: tb/tb_adc_capture.sv
// Randomized bench for adc_capture against a queue-based sample model.
// Two instances: offset-binary and two's-complement output.
module tb_adc_capture;
  import adda_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 16;
  localparam int HALF    = CLK_DIV / 2;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_enable = 1'b0;
  logic       i_ready = 1'b0;
  logic       i_clr_overflow = 1'b0;
  logic [7:0] i_ad_data = 8'h00;

  logic       o_adclk, o_valid, o_overflow;
  logic [7:0] o_data;
  logic [4:0] o_level;
  logic       s_adclk, s_valid, s_overflow;
  logic [7:0] s_data;
  logic [4:0] s_level;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  adc_capture #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .SIGNED_OUT(0)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_ad_data(i_ad_data), .o_adclk(o_adclk), .o_data(o_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_level(o_level),
    .o_overflow(o_overflow), .i_clr_overflow(i_clr_overflow)
  );

  adc_capture #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .SIGNED_OUT(1)) dut_s (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_ad_data(i_ad_data), .o_adclk(s_adclk), .o_data(s_data),
    .o_valid(s_valid), .i_ready(i_ready), .o_level(s_level),
    .o_overflow(s_overflow), .i_clr_overflow(i_clr_overflow)
  );

  // Reference model: the converter runs in whole periods of CLK_DIV
  // cycles; the last cycle of each period captures the bus value seen
  // one cycle earlier. The clock is high for the first half of a
  // period, delayed by its output register.
  logic [7:0] mq[$];
  bit         m_run = 0;
  int         m_ph = 0;
  bit         m_ovf = 0;
  bit         m_adclk = 0;
  logic [7:0] m_din = 8'h00;

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mq.delete();
      m_run = 0; m_ph = 0; m_ovf = 0; m_adclk = 0; m_din = 8'h00;
    end else begin
      bit pop_now, take, lost;
      pop_now = (mq.size() != 0) && i_ready;
      take = m_run && (m_ph == CLK_DIV - 1);
      m_adclk = m_run && (m_ph < HALF);
      lost = 0;
      if (pop_now) void'(mq.pop_front());
      if (take) begin
        if (mq.size() < DEPTH) mq.push_back(m_din);
        else lost = 1;
      end
      if (lost) m_ovf = 1;
      else if (i_clr_overflow) m_ovf = 0;
      if (!m_run) begin
        m_run = i_enable;
        m_ph = 0;
      end else if (m_ph == CLK_DIV - 1) begin
        m_run = i_enable;
        m_ph = 0;
      end else begin
        m_ph++;
      end
      m_din = i_ad_data;
    end
  end

  function automatic logic [15:0] obs();
    return {o_adclk, o_valid, o_level, o_overflow,
            o_valid ? o_data : 8'h00};
  endfunction

  function automatic logic [15:0] sobs();
    return {s_adclk, s_valid, s_level, s_overflow,
            s_valid ? s_data : 8'h00};
  endfunction

  function automatic logic [15:0] expv();
    bit v;
    v = (mq.size() != 0);
    return {m_adclk, v, 5'(mq.size()), m_ovf, v ? mq[0] : 8'h00};
  endfunction

  function automatic logic [15:0] sexpv();
    bit v;
    v = (mq.size() != 0);
    return {m_adclk, v, 5'(mq.size()), m_ovf,
            v ? (mq[0] ^ 8'h80) : 8'h00};
  endfunction

  task automatic apply_reset();
    i_reset = 1'b1;
    i_enable = 1'b0;
    i_ready = 1'b0;
    i_clr_overflow = 1'b0;
    i_ad_data = 8'h00;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_enable = 1'b1;
    i_ad_data = 8'hA5;
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if (obs() !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0000", obs());
    end
    checks++;
    if (o_data !== 8'h00 || s_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%h/%h exp=00", o_data, s_data);
    end
    apply_reset();
  endtask

  task automatic test_ramp();
    logic [7:0] prev;
    bit have;
    bit ah[$];
    have = 0;
    apply_reset();
    i_enable = 1'b1;
    i_ready = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(negedge i_clk);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL ramp got=%h exp=%h", obs(), expv());
      end
      ah.push_back(o_adclk);
      if (c >= 12) begin
        checks++;
        if (ah[c] !== ah[c-4] || ah[c] === ah[c-2]) begin
          failures++;
          $display("FAIL adclk_pattern cyc=%0d got=%b%b%b%b exp=1100 rotation",
                   c, ah[c-3], ah[c-2], ah[c-1], ah[c]);
        end
      end
      if (o_valid && i_ready) begin
        if (have) begin
          checks++;
          if (o_data !== prev + 8'(CLK_DIV)) begin
            failures++;
            $display("FAIL ramp_order got=%h exp=%h", o_data, prev + 8'(CLK_DIV));
          end
        end
        prev = o_data;
        have = 1;
      end
      i_ad_data = i_ad_data + 8'h01;
    end
    i_enable = 1'b0;
  endtask

  task automatic test_signed();
    logic [7:0] vals [3];
    logic [7:0] sexp [3];
    logic [7:0] r;
    r = 8'($urandom);
    vals[0] = 8'h80; sexp[0] = 8'h00;
    vals[1] = 8'hFF; sexp[1] = 8'h7F;
    vals[2] = r;     sexp[2] = {~r[7], r[6:0]};
    apply_reset();
    i_enable = 1'b1;
    i_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      i_ad_data = vals[v];
      for (int c = 0; c < 16; c++) begin
        @(negedge i_clk);
        checks++;
        if (sobs() !== sexpv()) begin
          failures++;
          $display("FAIL signed_model got=%h exp=%h", sobs(), sexpv());
        end
        if (c >= 8 && s_valid) begin
          checks++;
          if (s_data !== sexp[v] || o_data !== vals[v]) begin
            failures++;
            $display("FAIL signed_value in=%h got=%h/%h exp=%h/%h",
                     vals[v], s_data, o_data, sexp[v], vals[v]);
          end
        end
      end
    end
    i_enable = 1'b0;
  endtask

  task automatic test_overflow();
    int k;
    apply_reset();
    i_enable = 1'b1;
    i_ready = 1'b0;
    for (int c = 0; c < 20 * CLK_DIV + 2; c++) begin
      @(negedge i_clk);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL ovf_run got=%h exp=%h", obs(), expv());
      end
      i_ad_data = 8'($urandom);
    end
    checks++;
    if (o_level !== 5'd16 || o_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_full got=%0d/%b exp=16/1", o_level, o_overflow);
    end
    i_enable = 1'b0;
    k = 0;
    while (m_run && k < 4 * CLK_DIV) begin
      @(negedge i_clk);
      k++;
    end
    checks++;
    if (m_run) begin
      failures++;
      $display("FAIL ovf_stop_timeout got=run exp=idle");
    end
    i_clr_overflow = 1'b1;
    @(negedge i_clk);
    i_clr_overflow = 1'b0;
    checks++;
    if (o_overflow !== 1'b0 || obs() !== expv()) begin
      failures++;
      $display("FAIL ovf_clear got=%h exp=%h", obs(), expv());
    end
    i_ready = 1'b1;
    for (int c = 0; c < DEPTH + 2; c++) begin
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL ovf_drain got=%h exp=%h", obs(), expv());
      end
      @(negedge i_clk);
    end
    checks++;
    if (o_level !== 5'd0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_empty got=%0d/%b exp=0/0", o_level, o_valid);
    end
  endtask

  task automatic test_full_pushpop();
    int k;
    apply_reset();
    i_enable = 1'b1;
    i_ready = 1'b0;
    k = 0;
    while (mq.size() < DEPTH && k < 100) begin
      @(negedge i_clk);
      i_ad_data = i_ad_data + 8'h01;
      k++;
    end
    checks++;
    if (mq.size() < DEPTH) begin
      failures++;
      $display("FAIL fill_timeout got=%0d exp=%0d", o_level, DEPTH);
    end
    for (int c = 0; c < 3 * CLK_DIV; c++) begin
      i_ready = m_run && (m_ph == CLK_DIV - 1);
      @(negedge i_clk);
      i_ad_data = i_ad_data + 8'h01;
      checks++;
      if (o_level !== 5'd16 || o_overflow !== 1'b0 || obs() !== expv()) begin
        failures++;
        $display("FAIL full_pushpop got=%h exp=%h", obs(), expv());
      end
    end
    i_ready = 1'b0;
    i_enable = 1'b0;
    k = 0;
    while (m_run && k < 4 * CLK_DIV) begin
      @(negedge i_clk);
      k++;
    end
    i_ready = 1'b1;
    for (int c = 0; c < DEPTH + 3; c++) begin
      @(negedge i_clk);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL full_drain got=%h exp=%h", obs(), expv());
      end
    end
  endtask

  task automatic test_disable();
    int k;
    apply_reset();
    i_enable = 1'b1;
    i_ready = 1'b0;
    k = 0;
    while (!(mq.size() == 3 && m_ph == 1) && k < 60) begin
      @(negedge i_clk);
      i_ad_data = 8'($urandom);
      k++;
    end
    checks++;
    if (!(mq.size() == 3 && m_ph == 1)) begin
      failures++;
      $display("FAIL disable_wait_timeout got=%0d exp=3", o_level);
    end
    i_enable = 1'b0;
    for (int c = 0; c < 2 * CLK_DIV; c++) begin
      @(negedge i_clk);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL disable_run got=%h exp=%h", obs(), expv());
      end
    end
    checks++;
    if (o_adclk !== 1'b0 || o_level !== 5'd4) begin
      failures++;
      $display("FAIL disable_idle got=%b/%0d exp=0/4", o_adclk, o_level);
    end
    i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL disable_drain got=%h exp=%h", obs(), expv());
      end
      @(negedge i_clk);
    end
    checks++;
    if (o_level !== 5'd0) begin
      failures++;
      $display("FAIL disable_empty got=%0d exp=0", o_level);
    end
  endtask

  task automatic test_async_reset();
    int k;
    apply_reset();
    i_enable = 1'b1;
    i_ready = 1'b0;
    k = 0;
    while (mq.size() < 5 && k < 60) begin
      @(negedge i_clk);
      i_ad_data = 8'($urandom);
      k++;
    end
    checks++;
    if (o_level !== 5'd5) begin
      failures++;
      $display("FAIL areset_level5 got=%0d exp=5", o_level);
    end
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if (o_level !== 5'd0 || o_valid !== 1'b0 || o_adclk !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate got=%0d/%b/%b exp=0/0/0",
               o_level, o_valid, o_adclk);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    k = 0;
    do begin
      @(negedge i_clk);
      k++;
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL areset_restart got=%h exp=%h", obs(), expv());
      end
    end while (o_adclk !== 1'b1 && k < 10);
    checks++;
    if (o_adclk !== 1'b1 || k < 2) begin
      failures++;
      $display("FAIL areset_first_adclk got=%0d cycles exp>=2", k);
    end
    i_enable = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      i_ad_data = 8'($urandom);
      i_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 39) == 0) i_enable = ~i_enable;
      i_clr_overflow = ($urandom_range(0, 19) == 0);
      @(negedge i_clk);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, obs(), expv());
      end
      checks++;
      if (sobs() !== sexpv()) begin
        failures++;
        $display("FAIL random_signed cyc=%0d got=%h exp=%h", c, sobs(), sexpv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_signed();
    test_overflow();
    test_full_pushpop();
    test_disable();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
